innings_scorekeeper: RTL and testbench
======================================

// Module: innings_scorekeeper
// PURPOSE
//  Producer side of the scoreboard interface: accumulates LFSR-generated ball outcomes into per-team
//  packed score words, per-team ball counts and live innings counters, which the downstream
//  score comparator consumes.
//  Sequences innings 1 -> break -> innings 2 -> done, driven by that block's inningOver/gameOver
//  handshake outputs.
// PARAMETERS
//  MAX_BALLS    120  legal balls per innings; further balls ignored
//  MAX_WICKETS  10   wickets per innings; further balls ignored
//  WICKET_CODE  7    outcome code meaning "wicket, 0 runs"
// PORTS
//  clk_fpga       in   1   single system clock; all logic on posedge
//  reset          in   1   synchronous, active-high; clears all state
//  ball_valid     in   1   1-cycle strobe: a ball has been bowled, outcome is valid
//  outcome        in   3   0..6 = runs scored, WICKET_CODE = wicket
//  start_inning   in   1   1-cycle strobe: leave BREAK and begin innings 2
//  inning_over    in   1   from comparator: current innings complete
//  game_over      in   1   from comparator: match complete
//  team1Data      out  12  {runs[7:0], wickets[3:0]} for team 1
//  team2Data      out  12  {runs[7:0], wickets[3:0]} for team 2
//  team1Balls     out  7   legal balls faced by team 1
//  team2Balls     out  7   legal balls faced by team 2
//  binaryWickets  out  4   wickets of the innings in progress
//  balls          out  16  balls of the innings in progress (zero-extended)
//  batting_team   out  1   0 = team 1 batting, 1 = team 2 batting
//  phase          out  2   00 INN1, 01 BREAK, 10 INN2, 11 DONE
//  ball_ack       out  1   1-cycle pulse: ball was accepted and counted
// BEHAVIOUR
//  Reset values: all outputs 0; phase = INN1; batting_team = 0.
//  accept = ball_valid & (phase == INN1 | phase == INN2) & ~inning_over & ~game_over
//           & (cur_wkts < MAX_WICKETS) & (cur_balls < MAX_BALLS).
//  On accept, in the next cycle:
//   - the batting team's balls +1 and balls +1;
//   - outcome == WICKET_CODE: wickets +1, runs unchanged;
//   - otherwise runs += outcome (0..6), saturating at 255.
//   - ball_ack = 1 for exactly that cycle (1-cycle latency).
//  binaryWickets/balls mirror the batting team's wickets/ball count at all times.
//  Rejected balls (limit reached, wrong phase, inning_over/game_over high): no count change,
//  no ball_ack. ball_valid with inning_over in the same cycle: inning_over wins, ball dropped.
//  outcome is only sampled when ball_valid is high.
//  FSM:
//   - INN1 -> BREAK on inning_over: team1 words freeze; binaryWickets/balls show 0
//     from the next cycle.
//   - BREAK -> INN2 on start_inning: batting_team = 1; team2 counters start from 0.
//     start_inning outside BREAK is ignored.
//   - INN2 -> DONE on inning_over: all counters freeze.
//   - any state -> DONE on game_over (priority over all other transitions).
//   - DONE holds until reset.
//  The comparator registers inningOver one cycle after a limit is hit. The local accept guard
//  already blocks an over-limit ball in that gap, so at most MAX_BALLS balls and MAX_WICKETS
//  wickets are ever counted per innings.
//  Width rules: runs 8-bit saturating; wickets 4-bit (max 10); team balls 7-bit (max 120);
//  balls = {9'b0, cur_balls}.
//  Reset mid-innings or in DONE returns everything to reset values on the next edge.
// TESTING
//  1) reset; 6 balls of outcome 4 -> team1Data = {8'd24, 4'd0}, team1Balls = 6, balls = 6,
//     ball_ack x6.
//  2) 10 balls of outcome 7 -> binaryWickets = 10; 11th ball_valid gives no ack and no change;
//     inning_over -> phase = BREAK, balls = 0.
//  3) 120 balls of outcome 1 -> team1Data[11:4] = 120; ball 121 rejected; inning_over +
//     start_inning -> phase = INN2, batting_team = 1.
//  4) 60 balls of outcome 6 in INN1 -> runs saturate at 255, not 360 mod 256.
//  5) ball_valid and inning_over in the same cycle -> no ack, counts unchanged, BREAK entered.
//  6) reset asserted mid-INN2 with counts nonzero -> next cycle all outputs 0, phase = INN1;
//     game_over pulse in INN1 -> DONE, later balls ignored.

Source files
------------

// File: rtl/innings_scorekeeper.sv
// innings_scorekeeper: accumulates per-ball outcomes into per-team score words,
// ball counts and the live innings view, and sequences INN1 -> BREAK -> INN2 -> DONE
// from the comparator's inning_over / game_over handshake.
module innings_scorekeeper #(
  parameter int         MAX_BALLS   = 120,
  parameter int         MAX_WICKETS = 10,
  parameter logic [2:0] WICKET_CODE = 3'd7
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        ball_valid,
  input  logic [2:0]  outcome,
  input  logic        start_inning,
  input  logic        inning_over,
  input  logic        game_over,
  output logic [11:0] team1Data,
  output logic [11:0] team2Data,
  output logic [6:0]  team1Balls,
  output logic [6:0]  team2Balls,
  output logic [3:0]  binaryWickets,
  output logic [15:0] balls,
  output logic        batting_team,
  output logic [1:0]  phase,
  output logic        ball_ack
);

  typedef enum logic [1:0] {INN1 = 2'b00, BRK = 2'b01, INN2 = 2'b10, DONE = 2'b11} phase_t;

  localparam logic [6:0] MAXB = 7'(MAX_BALLS);
  localparam logic [3:0] MAXW = 4'(MAX_WICKETS);

  phase_t     state_q, state_d;
  logic       bat_q, bat_d;
  logic       ack_q, ack_d;
  logic [7:0] t1_runs_q, t1_runs_d, t2_runs_q, t2_runs_d;
  logic [3:0] t1_wkts_q, t1_wkts_d, t2_wkts_q, t2_wkts_d;
  logic [6:0] t1_balls_q, t1_balls_d, t2_balls_q, t2_balls_d;

  logic [7:0] cur_runs;
  logic [3:0] cur_wkts;
  logic [6:0] cur_balls;
  logic [8:0] run_sum;
  logic [7:0] run_sat;
  logic       in_play;
  logic       accept;

  // Batting team's live counters, saturating run update and the ball-accept guard.
  always_comb begin
    cur_runs  = bat_q ? t2_runs_q  : t1_runs_q;
    cur_wkts  = bat_q ? t2_wkts_q  : t1_wkts_q;
    cur_balls = bat_q ? t2_balls_q : t1_balls_q;
    run_sum   = {1'b0, cur_runs} + {6'b0, outcome};
    run_sat   = run_sum[8] ? 8'hFF : run_sum[7:0];
    in_play   = (state_q == INN1) || (state_q == INN2);
    accept    = ball_valid && in_play && !inning_over && !game_over &&
                (cur_wkts < MAXW) && (cur_balls < MAXB);
  end

  // Phase sequencing; game_over overrides every other transition.
  always_comb begin
    state_d = state_q;
    bat_d   = bat_q;
    if (game_over) begin
      state_d = DONE;
    end else begin
      case (state_q)
        INN1: if (inning_over) state_d = BRK;
        BRK:  if (start_inning) begin
                state_d = INN2;
                bat_d   = 1'b1;
              end
        INN2: if (inning_over) state_d = DONE;
        default: state_d = DONE;
      endcase
    end
  end

  // Counter next-state: only the batting team's counters move, and only on accept.
  always_comb begin
    t1_runs_d  = t1_runs_q;
    t1_wkts_d  = t1_wkts_q;
    t1_balls_d = t1_balls_q;
    t2_runs_d  = t2_runs_q;
    t2_wkts_d  = t2_wkts_q;
    t2_balls_d = t2_balls_q;
    ack_d      = accept;
    if (accept) begin
      if (bat_q) begin
        t2_balls_d = t2_balls_q + 7'd1;
        if (outcome == WICKET_CODE) t2_wkts_d = t2_wkts_q + 4'd1;
        else                        t2_runs_d = run_sat;
      end else begin
        t1_balls_d = t1_balls_q + 7'd1;
        if (outcome == WICKET_CODE) t1_wkts_d = t1_wkts_q + 4'd1;
        else                        t1_runs_d = run_sat;
      end
    end
  end

  // State and counter registers with synchronous clear.
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state_q    <= INN1;
      bat_q      <= 1'b0;
      ack_q      <= 1'b0;
      t1_runs_q  <= '0;
      t1_wkts_q  <= '0;
      t1_balls_q <= '0;
      t2_runs_q  <= '0;
      t2_wkts_q  <= '0;
      t2_balls_q <= '0;
    end else begin
      state_q    <= state_d;
      bat_q      <= bat_d;
      ack_q      <= ack_d;
      t1_runs_q  <= t1_runs_d;
      t1_wkts_q  <= t1_wkts_d;
      t1_balls_q <= t1_balls_d;
      t2_runs_q  <= t2_runs_d;
      t2_wkts_q  <= t2_wkts_d;
      t2_balls_q <= t2_balls_d;
    end
  end

  // Output view; the live innings counters read zero during the break.
  always_comb begin
    team1Data     = {t1_runs_q, t1_wkts_q};
    team2Data     = {t2_runs_q, t2_wkts_q};
    team1Balls    = t1_balls_q;
    team2Balls    = t2_balls_q;
    batting_team  = bat_q;
    phase         = state_q;
    ball_ack      = ack_q;
    binaryWickets = (state_q == BRK) ? 4'd0 : cur_wkts;
    balls         = (state_q == BRK) ? 16'd0 : {9'b0, cur_balls};
  end

endmodule

// File: tb/tb_innings_scorekeeper.sv
// Directed bench for innings_scorekeeper: hand-computed expectations per step.
module tb_innings_scorekeeper;

  logic        clk_fpga = 1'b0;
  logic        reset = 1'b1;
  logic        ball_valid = 1'b0;
  logic [2:0]  outcome = 3'd0;
  logic        start_inning = 1'b0;
  logic        inning_over = 1'b0;
  logic        game_over = 1'b0;
  logic [11:0] team1Data, team2Data;
  logic [6:0]  team1Balls, team2Balls;
  logic [3:0]  binaryWickets;
  logic [15:0] balls;
  logic        batting_team;
  logic [1:0]  phase;
  logic        ball_ack;

  int checks = 0;
  int failures = 0;

  innings_scorekeeper dut (
    .clk_fpga(clk_fpga), .reset(reset), .ball_valid(ball_valid), .outcome(outcome),
    .start_inning(start_inning), .inning_over(inning_over), .game_over(game_over),
    .team1Data(team1Data), .team2Data(team2Data), .team1Balls(team1Balls),
    .team2Balls(team2Balls), .binaryWickets(binaryWickets), .balls(balls),
    .batting_team(batting_team), .phase(phase), .ball_ack(ball_ack)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on negedge; outputs are sampled one negedge later, after the posedge.
  task automatic do_reset();
    @(negedge clk_fpga); reset = 1'b1;
    @(negedge clk_fpga); reset = 1'b0;
  endtask

  task automatic ball(input logic [2:0] o, input logic exp_ack, input string tag);
    @(negedge clk_fpga); ball_valid = 1'b1; outcome = o;
    @(negedge clk_fpga); ball_valid = 1'b0; outcome = 3'd0;
    chk(tag, {31'b0, ball_ack}, {31'b0, exp_ack});
  endtask

  task automatic pulse_io();
    @(negedge clk_fpga); inning_over = 1'b1;
    @(negedge clk_fpga); inning_over = 1'b0;
  endtask

  task automatic pulse_si();
    @(negedge clk_fpga); start_inning = 1'b1;
    @(negedge clk_fpga); start_inning = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_t1data", team1Data, 0);
    chk("rst_t2data", team2Data, 0);
    chk("rst_balls", balls, 0);
    chk("rst_phase", phase, 0);
    chk("rst_bat", batting_team, 0);
    chk("rst_ack", ball_ack, 0);

    // 1) six fours
    for (int i = 0; i < 6; i++) ball(3'd4, 1'b1, "t1_ack");
    @(negedge clk_fpga);
    chk("t1_ack_clears", ball_ack, 0);
    chk("t1_data", team1Data, {8'd24, 4'd0});
    chk("t1_tballs", team1Balls, 6);
    chk("t1_balls", balls, 6);

    // 2) ten wickets, then over-limit ball, then break
    do_reset();
    for (int i = 0; i < 10; i++) ball(3'd7, 1'b1, "t2_ack");
    chk("t2_wkts", binaryWickets, 10);
    chk("t2_data", team1Data, {8'd0, 4'd10});
    ball(3'd3, 1'b0, "t2_11th_noack");
    chk("t2_11th_balls", team1Balls, 10);
    chk("t2_11th_data", team1Data, {8'd0, 4'd10});
    pulse_io();
    chk("t2_phase_brk", phase, 1);
    chk("t2_brk_balls", balls, 0);
    chk("t2_brk_wkts", binaryWickets, 0);
    chk("t2_t1_frozen", team1Data, {8'd0, 4'd10});

    // 3) full 120 balls, ball 121 rejected, move to innings 2
    do_reset();
    for (int i = 0; i < 120; i++) ball(3'd1, 1'b1, "t3_ack");
    chk("t3_runs", team1Data[11:4], 120);
    chk("t3_tballs", team1Balls, 120);
    ball(3'd1, 1'b0, "t3_121_noack");
    chk("t3_121_balls", team1Balls, 120);
    chk("t3_121_runs", team1Data[11:4], 120);
    pulse_io();
    pulse_si();
    chk("t3_phase_inn2", phase, 2);
    chk("t3_bat", batting_team, 1);
    chk("t3_inn2_balls0", balls, 0);
    ball(3'd3, 1'b1, "t3_inn2_ack");
    chk("t3_t2data", team2Data, {8'd3, 4'd0});
    chk("t3_t2balls", team2Balls, 1);
    chk("t3_inn2_balls", balls, 1);
    chk("t3_t1_frozen", team1Data, {8'd120, 4'd0});

    // 6a) reset mid-INN2 with nonzero counts
    @(negedge clk_fpga); reset = 1'b1;
    @(negedge clk_fpga);
    chk("t6_t1data", team1Data, 0);
    chk("t6_t2data", team2Data, 0);
    chk("t6_t1balls", team1Balls, 0);
    chk("t6_t2balls", team2Balls, 0);
    chk("t6_balls", balls, 0);
    chk("t6_phase", phase, 0);
    chk("t6_bat", batting_team, 0);
    reset = 1'b0;

    // 6b) game_over in INN1 -> DONE, later balls ignored
    @(negedge clk_fpga); game_over = 1'b1;
    @(negedge clk_fpga); game_over = 1'b0;
    chk("t6_done", phase, 3);
    ball(3'd5, 1'b0, "t6_done_noack");
    chk("t6_done_balls", team1Balls, 0);
    pulse_si();
    chk("t6_done_hold", phase, 3);

    // 4) saturation at 255
    do_reset();
    for (int i = 0; i < 60; i++) ball(3'd6, 1'b1, "t4_ack");
    chk("t4_runs_sat", team1Data[11:4], 255);
    chk("t4_tballs", team1Balls, 60);

    // 5) ball_valid with inning_over in the same cycle
    do_reset();
    ball(3'd2, 1'b1, "t5_ack");
    ball(3'd2, 1'b1, "t5_ack");
    pulse_si();
    chk("t5_si_ignored", phase, 0);
    @(negedge clk_fpga); ball_valid = 1'b1; outcome = 3'd4; inning_over = 1'b1;
    @(negedge clk_fpga); ball_valid = 1'b0; outcome = 3'd0; inning_over = 1'b0;
    chk("t5_same_noack", ball_ack, 0);
    chk("t5_same_tballs", team1Balls, 2);
    chk("t5_same_data", team1Data, {8'd4, 4'd0});
    chk("t5_same_brk", phase, 1);
    ball(3'd4, 1'b0, "t5_brk_noack");
    chk("t5_brk_tballs", team1Balls, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
